// File: rtl/hamming_rx_controller.sv
// Hamming(7,4) RX controller: gates the receiver, corrects single-bit errors, pairs nibbles into bytes and buffers them.
// Optional corrected-codeword counter enabled by defining HAMMING_RX_STATS_EN.
module hamming_rx_controller #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [6:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ena,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       corrected,
  output logic       frame_drop,
  output logic       overflow,
  output logic [7:0] err_count,
  input  logic       clear_stats
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    LO_WAIT,
    HI_WAIT
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [3:0]      lo;
  logic            push_pend;
  logic [7:0]      push_byte;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic [2:0]      syn;
  logic [6:0]      cw_fix;
  logic [3:0]      nibble;
  logic            accept;
  logic            corr_evt;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            wr_en;

  assign syn = {rx_data[3] ^ rx_data[4] ^ rx_data[5] ^ rx_data[6],
                rx_data[1] ^ rx_data[2] ^ rx_data[5] ^ rx_data[6],
                rx_data[0] ^ rx_data[2] ^ rx_data[4] ^ rx_data[6]};

  // The syndrome is the 1-based position of the flipped bit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cw_fix = rx_data;
    if (syn != 3'd0) cw_fix = rx_data ^ (7'd1 << (syn - 3'd1));
    nibble = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
  end

  assign accept    = ena & rx_valid;
  assign corr_evt  = accept & (syn != 3'd0);
  assign fifo_full = (count == FULL_CNT);
  assign rx_ena    = ena & ~fifo_full;

  assign push  = ena & push_pend;
  assign pop   = ena & out_valid & out_ready;
  assign wr_en = push & (~fifo_full | pop);

  // Nibble pairing FSM; the assembled byte is staged one cycle before it enters the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LO_WAIT;
      timer      <= '0;
      lo         <= '0;
      push_pend  <= 1'b0;
      push_byte  <= '0;
      corrected  <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
      corrected  <= corr_evt;
      frame_drop <= 1'b0;
      if (ena) begin
        push_pend <= 1'b0;
        case (state)
          LO_WAIT: begin
            if (rx_valid) begin
              lo    <= nibble;
              timer <= '0;
              state <= HI_WAIT;
            end
          end
          HI_WAIT: begin
            if (rx_valid) begin
              push_pend <= 1'b1;
              push_byte <= {nibble, lo};
              state     <= LO_WAIT;
            end else if (timer == T_LAST) begin
              frame_drop <= 1'b1;
              state      <= LO_WAIT;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: state <= LO_WAIT;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; out_data is masked while empty so stale entries never show.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + (AW + 1)'(1);
      else if (!wr_en && pop) count <= count - (AW + 1)'(1);
      // A dropped byte outranks a clear in the same cycle.
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (clear_stats)          overflow <= 1'b0;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

`ifdef HAMMING_RX_STATS_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 8'h00;
    end else if (corr_evt) begin
      if (clear_stats)          err_q <= 8'd1;
      else if (err_q != 8'hFF)  err_q <= err_q + 8'd1;
    end else if (clear_stats) begin
      err_q <= 8'h00;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule
